// File: rtl/uart_tx.sv
// UART transmitter: serialises a byte as start, LSB-first data, optional parity and stop bits,
// each bit lasting Prescale CLK cycles.
module uart_tx #(
    parameter int DATA_WIDTH     = 8,
    parameter int PRESCALE_WIDTH = 6
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic [DATA_WIDTH-1:0]     P_DATA,
    input  logic                      Data_Valid,
    input  logic                      PAR_EN,
    input  logic                      PAR_TYP,
    input  logic [PRESCALE_WIDTH-1:0] Prescale,
    output logic                      TX_OUT,
    output logic                      busy
);

    localparam int BCW = $clog2(DATA_WIDTH) + 1;

    typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;

    state_e                    state_q;
    logic [PRESCALE_WIDTH-1:0] edge_cnt_q;
    logic [PRESCALE_WIDTH-1:0] prescale_q;
    logic [BCW-1:0]            bit_cnt_q;
    logic [DATA_WIDTH-1:0]     shreg_q;
    logic [DATA_WIDTH-1:0]     shreg_shift;
    logic                      par_en_q;
    logic                      par_bit_q;
    logic                      bit_done;

    assign bit_done    = (edge_cnt_q == prescale_q - PRESCALE_WIDTH'(1));
    assign shreg_shift = shreg_q >> 1;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q    <= StIdle;
            edge_cnt_q <= '0;
            prescale_q <= '0;
            bit_cnt_q  <= '0;
            shreg_q    <= '0;
            par_en_q   <= 1'b0;
            par_bit_q  <= 1'b0;
            TX_OUT     <= 1'b1;
            busy       <= 1'b0;
        end else if (state_q == StIdle) begin
            TX_OUT <= 1'b1;
            busy   <= 1'b0;
            if (Data_Valid) begin
                // Parity is resolved at acceptance since the shift register is consumed in flight.
                shreg_q    <= P_DATA;
                par_en_q   <= PAR_EN;
                par_bit_q  <= (^P_DATA) ^ PAR_TYP;
                prescale_q <= (Prescale == '0) ? PRESCALE_WIDTH'(1) : Prescale;
                edge_cnt_q <= '0;
                state_q    <= StStart;
                TX_OUT     <= 1'b0;
                busy       <= 1'b1;
            end
        end else if (!bit_done) begin
            edge_cnt_q <= edge_cnt_q + PRESCALE_WIDTH'(1);
        end else begin
            edge_cnt_q <= '0;
            unique case (state_q)
                StStart: begin
                    state_q   <= StData;
                    bit_cnt_q <= '0;
                    TX_OUT    <= shreg_q[0];
                end
                StData: begin
                    if (bit_cnt_q == BCW'(DATA_WIDTH - 1)) begin
                        state_q <= par_en_q ? StParity : StStop;
                        TX_OUT  <= par_en_q ? par_bit_q : 1'b1;
                    end else begin
                        bit_cnt_q <= bit_cnt_q + BCW'(1);
                        shreg_q   <= shreg_shift;
                        TX_OUT    <= shreg_shift[0];
                    end
                end
                StParity: begin
                    state_q <= StStop;
                    TX_OUT  <= 1'b1;
                end
                default: begin
                    state_q <= StIdle;
                    TX_OUT  <= 1'b1;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule
